// File: rtl/addsub_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one add/sub datapath, sequenced IDLE -> EXEC -> RESP.
// Optional signed-overflow outputs rsp0_ovf/rsp1_ovf are enabled by defining ADDSUB_ARB_OVF_EN.
module addsub_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_cout,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_cout
`ifdef ADDSUB_ARB_OVF_EN
    ,
    output logic             rsp0_ovf,
    output logic             rsp1_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             owner_p0;
    logic             last_grant;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             sub_p0;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH:0]   res_p1;
    logic             ovf_p1;

    // Subtraction reuses the adder: invert B and inject the carry-in.
    function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sub);
        logic [WIDTH-1:0] b_eff;
        b_eff = b ^ {WIDTH{sub}};
        return {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    endfunction

    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic                    sub,
                                        input logic signed [WIDTH-1:0] sum);
        logic signed [WIDTH-1:0] b_eff;
        b_eff = b ^ {WIDTH{sub}};
        return (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Contention favours whichever requester was not served last.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || last_grant);
        gnt1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == IDLE) && gnt0;
    assign req1_ready = (state == IDLE) && gnt1;

    always_comb begin
        res_p1 = add_sub(a_p0, b_p0, sub_p0);
        ovf_p1 = signed_ovf(a_p0, b_p0, sub_p0, res_p1[WIDTH-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_p0   <= 1'b0;
            last_grant <= 1'b1;
            a_p0       <= '0;
            b_p0       <= '0;
            sub_p0     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_sum   <= '0;
            rsp0_cout  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_sum   <= '0;
            rsp1_cout  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            rsp0_ovf   <= 1'b0;
            rsp1_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                // Stage p0: capture the granted request
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_p0       <= gnt1 ? req1_a : req0_a;
                        b_p0       <= gnt1 ? req1_b : req0_b;
                        sub_p0     <= gnt1 ? req1_sub : req0_sub;
                        owner_p0   <= gnt1;
                        last_grant <= gnt1;
                        state      <= EXEC;
                    end
                end
                // Stage p1: compute and register into the owner's response
                EXEC: begin
                    if (!owner_p0) begin
                        rsp0_sum   <= res_p1[WIDTH-1:0];
                        rsp0_cout  <= res_p1[WIDTH];
                        rsp0_valid <= 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
                        rsp0_ovf   <= ovf_p1;
`endif
                    end else begin
                        rsp1_sum   <= res_p1[WIDTH-1:0];
                        rsp1_cout  <= res_p1[WIDTH];
                        rsp1_valid <= 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
                        rsp1_ovf   <= ovf_p1;
`endif
                    end
                    state <= RESP;
                end
                // Stage p2: hold the result until the owner takes it
                RESP: begin
                    if (!owner_p0 && rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (owner_p0 && rsp1_ready) begin
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ADDSUB_ARB_OVF_EN
    logic unused_ovf;
    assign unused_ovf = ovf_p1;
`endif

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Scoreboard bench for addsub_rr_arbiter: expected results queued at request handshake, checked at response handshake.
// Define ADDSUB_ARB_OVF_EN to also check the signed-overflow outputs.
module tb_addsub_rr_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_sub = 1'b0, req1_sub = 1'b0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [W-1:0] rsp0_sum, rsp1_sum;
    logic         rsp0_cout, rsp1_cout;
`ifdef ADDSUB_ARB_OVF_EN
    logic         rsp0_ovf, rsp1_ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [W+1:0] exp_q0[$];
    logic [W+1:0] exp_q1[$];
    int           glog[$];

    always #5 clk = ~clk;

    addsub_rr_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout)
`ifdef ADDSUB_ARB_OVF_EN
        , .rsp0_ovf(rsp0_ovf), .rsp1_ovf(rsp1_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int ai, bi, r, sa, sb, sr;
        logic [W-1:0] s;
        logic c, v;
        ai = int'(a);
        bi = int'(b);
        r  = sub ? ai - bi : ai + bi;
        s  = W'(r & ((1 << W) - 1));
        c  = sub ? (ai >= bi) : (r >= (1 << W));
        sa = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
        sb = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
        sr = sub ? sa - sb : sa + sb;
        v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {v, c, s};
    endfunction

    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            glog.delete();
        end else begin
            check("ready_mutex", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_valid && req0_ready) begin
                exp_q0.push_back(model(req0_a, req0_b, req0_sub));
                glog.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                exp_q1.push_back(model(req1_a, req1_b, req1_sub));
                glog.push_back(1);
            end
            if (rsp0_valid && rsp0_ready) begin
                if (exp_q0.size() == 0) check("rsp0_spurious", 32'd1, 32'd0);
                else begin
                    e = exp_q0.pop_front();
                    check("rsp0_sum", {28'd0, rsp0_sum}, {28'd0, e[W-1:0]});
                    check("rsp0_cout", {31'd0, rsp0_cout}, {31'd0, e[W]});
`ifdef ADDSUB_ARB_OVF_EN
                    check("rsp0_ovf", {31'd0, rsp0_ovf}, {31'd0, e[W+1]});
`endif
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp_q1.size() == 0) check("rsp1_spurious", 32'd1, 32'd0);
                else begin
                    e = exp_q1.pop_front();
                    check("rsp1_sum", {28'd0, rsp1_sum}, {28'd0, e[W-1:0]});
                    check("rsp1_cout", {31'd0, rsp1_cout}, {31'd0, e[W]});
`ifdef ADDSUB_ARB_OVF_EN
                    check("rsp1_ovf", {31'd0, rsp1_ovf}, {31'd0, e[W+1]});
`endif
                end
            end
        end
    end

    // Holds the request until accepted; returns 1 time unit after the accepting edge.
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bit done = 0;
        if (id == 0) begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
        else         begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) done = 1;
        end
        if (!done) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {31'd0, n >= 50}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check("rst_rsp0_sum", {28'd0, rsp0_sum}, 32'd0);
        check("rst_rsp1_cout", {31'd0, rsp1_cout}, 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Add with latency probe
        issue(0, 4'b1000, 4'b0010, 1'b0);
        @(negedge clk);
        check("lat_exec", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        check("lat_resp", {31'd0, rsp0_valid}, 32'd1);
        check("add_sum", {28'd0, rsp0_sum}, 32'b1010);
        drain();

        // Subtract, with and without borrow
        issue(1, 4'b1000, 4'b0010, 1'b1);
        drain();
        issue(1, 4'b0010, 4'b1000, 1'b1);
        drain();

        // Contention: both requesters keep requests pending
        glog.delete();
        fork
            begin issue(0, 4'd3, 4'd5, 1'b0); issue(0, 4'd9, 4'd12, 1'b1); end
            begin issue(1, 4'd7, 4'd7, 1'b1); issue(1, 4'd15, 4'd15, 1'b0); end
        join
        drain();
        check("cont_len", glog.size(), 32'd4);
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) check("cont_order", glog[i], i % 2);
        end

        // Backpressure on requester 0 while requester 1 waits
        rsp0_ready = 1'b0;
        issue(0, 4'b1110, 4'b1111, 1'b0);
        req1_a = 4'd3; req1_b = 4'd1; req1_sub = 1'b0; req1_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp0_valid}, 32'd1);
            check("bp_sum", {28'd0, rsp0_sum}, 32'b1101);
            check("bp_cout", {31'd0, rsp0_cout}, 32'd1);
            check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_req1_ready_resp", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        check("bp_idle", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        drain();

        // Reset while in RESP
        rsp0_ready = 1'b0;
        issue(0, 4'd5, 4'd6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, rsp0_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_resp_valid", {31'd0, rsp0_valid}, 32'd0);
        check("rst_resp_sum", {28'd0, rsp0_sum}, 32'd0);
        #10 rst_n = 1'b1;
        rsp0_ready = 1'b1;
        @(posedge clk); #1;

        // Reset while in EXEC
        issue(0, 4'd1, 4'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_exec_valid0", {31'd0, rsp0_valid}, 32'd0);
        check("rst_exec_valid1", {31'd0, rsp1_valid}, 32'd0);
        check("rst_exec_sum0", {28'd0, rsp0_sum}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Pointer back to 1: contended request goes to requester 0 first
        fork
            issue(0, 4'd2, 4'd2, 1'b0);
            issue(1, 4'd6, 4'd9, 1'b1);
        join
        drain();
        check("post_rst_len", glog.size(), 32'd2);
        if (glog.size() == 2) begin
            check("post_rst_first", glog[0], 32'd0);
            check("post_rst_second", glog[1], 32'd1);
        end

`ifdef ADDSUB_ARB_OVF_EN
        issue(0, 4'b0111, 4'b0001, 1'b0);
        drain();
        issue(0, 4'b1000, 4'b0001, 1'b1);
        drain();
        issue(1, 4'b0011, 4'b0010, 1'b0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
